// File: rtl/core_socket_scheduler_pkg.sv
// Shared state encodings and elaboration-time helpers for the core socket scheduler.
package core_socket_scheduler_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Ceiling log2 for parameter sizing; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/core_socket_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after ptr, wrapping modulo N.
module rr_arbiter
   import core_socket_scheduler_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any
);

   logic [IW-1:0] idx;

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         idx = IW'((int'(ptr) + k) % N);
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/core_socket_scheduler.sv
// Dispatches jobs round-robin to CORES attached cores and returns their results, tagged, through one output register.
module core_socket_scheduler
   import core_socket_scheduler_pkg::*;
#(
   parameter  int DATA_SIZE = 16,
   parameter  int CORES     = 4,
   parameter  int TAG_W     = 4,
   localparam int ID_W      = clog2(CORES)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       job_valid,
   output logic                       job_ready,
   input  logic [TAG_W-1:0]           job_tag,
   input  logic [DATA_SIZE-1:0]       job_data,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [TAG_W-1:0]           res_tag,
   output logic [ID_W-1:0]            res_core,
   output logic [DATA_SIZE-1:0]       res_data,
   output logic [CORES-1:0]           core_start,
   output logic [CORES*DATA_SIZE-1:0] core_data,
   input  logic [CORES-1:0]           core_done,
   input  logic [CORES*DATA_SIZE-1:0] core_result,
   output logic [ID_W:0]              busy_cnt,
   output logic                       err_spurious
);

   logic                 rdy_en;
   logic [CORES-1:0]     idle_vec, done_vec, spurious_vec;
   logic [TAG_W-1:0]     tag_arr    [CORES];
   logic [DATA_SIZE-1:0] result_arr [CORES];
   logic [ID_W-1:0]      disp_ptr, coll_ptr, disp_idx, coll_idx;
   logic [CORES-1:0]     disp_grant, coll_grant;
   logic                 disp_any, coll_any;
   logic                 accept, load;

   rr_arbiter #(.N(CORES), .IW(ID_W)) u_dispatch (
      .req       (idle_vec),
      .ptr       (disp_ptr),
      .grant     (disp_grant),
      .grant_idx (disp_idx),
      .any       (disp_any)
   );

   rr_arbiter #(.N(CORES), .IW(ID_W)) u_collect (
      .req       (done_vec),
      .ptr       (coll_ptr),
      .grant     (coll_grant),
      .grant_idx (coll_idx),
      .any       (coll_any)
   );

   // rdy_en holds job_ready low while in reset and releases it on the first edge afterwards.
   assign job_ready = rdy_en && disp_any;
   assign accept    = job_valid && job_ready;
   assign load      = coll_any && (!res_valid || res_ready);

   for (genvar i = 0; i < CORES; i++) begin : g_core
      logic [1:0]           st;
      logic [TAG_W-1:0]     tag_q;
      logic [DATA_SIZE-1:0] result_q;
      logic                 start_q;
      logic [DATA_SIZE-1:0] data_q;

      // NOTE: the small per-core tag/result stores sit on the async reset so no stale job survives reset.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st       <= ST_IDLE;
            tag_q    <= '0;
            result_q <= '0;
            start_q  <= 1'b0;
            data_q   <= '0;
         end else begin
            start_q <= accept && disp_grant[i];
            data_q  <= (accept && disp_grant[i]) ? job_data : '0;
            case (st)
               ST_IDLE: if (accept && disp_grant[i]) begin
                  st    <= ST_BUSY;
                  tag_q <= job_tag;
               end
               ST_BUSY: if (core_done[i]) begin
                  st       <= ST_DONE;
                  result_q <= core_result[i*DATA_SIZE +: DATA_SIZE];
               end
               ST_DONE: if (load && coll_grant[i]) st <= ST_IDLE;
               default: st <= ST_IDLE;
            endcase
         end
      end

      assign idle_vec[i]                           = (st == ST_IDLE);
      assign done_vec[i]                           = (st == ST_DONE);
      assign spurious_vec[i]                       = core_done[i] && (st != ST_BUSY);
      assign tag_arr[i]                            = tag_q;
      assign result_arr[i]                         = result_q;
      assign core_start[i]                         = start_q;
      assign core_data[i*DATA_SIZE +: DATA_SIZE]   = data_q;
   end

   always_comb begin
      busy_cnt = '0;
      for (int i = 0; i < CORES; i++)
         busy_cnt = busy_cnt + {{ID_W{1'b0}}, ~idle_vec[i]};
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en       <= 1'b0;
         disp_ptr     <= '0;
         coll_ptr     <= '0;
         res_valid    <= 1'b0;
         res_tag      <= '0;
         res_core     <= '0;
         res_data     <= '0;
         err_spurious <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         if (accept)
            disp_ptr <= (disp_idx == ID_W'(CORES-1)) ? '0 : disp_idx + 1'b1;
         if (load) begin
            res_valid <= 1'b1;
            res_tag   <= tag_arr[coll_idx];
            res_core  <= coll_idx;
            res_data  <= result_arr[coll_idx];
            coll_ptr  <= (coll_idx == ID_W'(CORES-1)) ? '0 : coll_idx + 1'b1;
         end else if (res_ready) begin
            res_valid <= 1'b0;
         end
         if (|spurious_vec)
            err_spurious <= 1'b1;
      end
   end

endmodule

// File: tb/tb_core_socket_scheduler.sv
// Directed bench for core_socket_scheduler: per-cycle vector table plus hand-written reset and spurious-done sequences.
module tb_core_socket_scheduler;

   logic        clk;
   logic        rst_n;
   logic        job_valid;
   logic        job_ready;
   logic [3:0]  job_tag;
   logic [15:0] job_data;
   logic        res_valid;
   logic        res_ready;
   logic [3:0]  res_tag;
   logic [1:0]  res_core;
   logic [15:0] res_data;
   logic [3:0]  core_start;
   logic [63:0] core_data;
   logic [3:0]  core_done;
   logic [63:0] core_result;
   logic [2:0]  busy_cnt;
   logic        err_spurious;

   int tests  = 0;
   int failed = 0;

   core_socket_scheduler #(.DATA_SIZE(16), .CORES(4), .TAG_W(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .job_valid    (job_valid),
      .job_ready    (job_ready),
      .job_tag      (job_tag),
      .job_data     (job_data),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_tag      (res_tag),
      .res_core     (res_core),
      .res_data     (res_data),
      .core_start   (core_start),
      .core_data    (core_data),
      .core_done    (core_done),
      .core_result  (core_result),
      .busy_cnt     (busy_cnt),
      .err_spurious (err_spurious)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        jv;
      logic [3:0]  tag;
      logic [15:0] jdata;
      logic        rr;
      logic [3:0]  cdone;
      logic [63:0] cres;
      logic        e_ready;
      logic [3:0]  e_start;
      logic [63:0] e_cdata;
      logic [2:0]  e_busy;
      logic        e_rv;
      logic [3:0]  e_tag;
      logic [1:0]  e_core;
      logic [15:0] e_data;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic jv, input logic [3:0] tag, input logic [15:0] jdata,
                      input logic rr, input logic [3:0] cdone, input logic [63:0] cres,
                      input logic e_ready, input logic [3:0] e_start, input logic [63:0] e_cdata,
                      input logic [2:0] e_busy, input logic e_rv, input logic [3:0] e_tag,
                      input logic [1:0] e_core, input logic [15:0] e_data);
      vec_t v;
      v.jv = jv; v.tag = tag; v.jdata = jdata; v.rr = rr; v.cdone = cdone; v.cres = cres;
      v.e_ready = e_ready; v.e_start = e_start; v.e_cdata = e_cdata; v.e_busy = e_busy;
      v.e_rv = e_rv; v.e_tag = e_tag; v.e_core = e_core; v.e_data = e_data;
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end within the time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Each row: inputs driven for one cycle, outputs expected during that same cycle (before its edge).
      // Four jobs fill cores 0..3, the fifth stalls.
      add(1, 4'd1, 16'h0A01, 1, 4'b0000, 64'h0, 1, 4'b0000, 64'h0,                   3'd0, 0, 4'd0, 2'd0, 16'h0);
      add(1, 4'd2, 16'h0A02, 1, 4'b0000, 64'h0, 1, 4'b0001, 64'h0000_0000_0000_0A01, 3'd1, 0, 4'd0, 2'd0, 16'h0);
      add(1, 4'd3, 16'h0A03, 1, 4'b0000, 64'h0, 1, 4'b0010, 64'h0000_0000_0A02_0000, 3'd2, 0, 4'd0, 2'd0, 16'h0);
      add(1, 4'd4, 16'h0A04, 1, 4'b0000, 64'h0, 1, 4'b0100, 64'h0000_0A03_0000_0000, 3'd3, 0, 4'd0, 2'd0, 16'h0);
      add(1, 4'd5, 16'h0A05, 1, 4'b0000, 64'h0, 0, 4'b1000, 64'h0A04_0000_0000_0000, 3'd4, 0, 4'd0, 2'd0, 16'h0);
      add(1, 4'd5, 16'h0A05, 1, 4'b0000, 64'h0, 0, 4'b0000, 64'h0,                   3'd4, 0, 4'd0, 2'd0, 16'h0);
      add(0, 4'd0, 16'h0000, 1, 4'b0000, 64'h0, 0, 4'b0000, 64'h0,                   3'd4, 0, 4'd0, 2'd0, 16'h0);
      // Cores 0 and 2 finish together; collected core 0 first, then core 2.
      add(0, 4'd0, 16'h0000, 1, 4'b0101, 64'h0000_BEEF_0000_1234, 0, 4'b0000, 64'h0, 3'd4, 0, 4'd0, 2'd0, 16'h0);
      add(0, 4'd0, 16'h0000, 1, 4'b0000, 64'h0, 0, 4'b0000, 64'h0,                   3'd4, 0, 4'd0, 2'd0, 16'h0);
      add(0, 4'd0, 16'h0000, 1, 4'b0000, 64'h0, 1, 4'b0000, 64'h0,                   3'd3, 1, 4'd1, 2'd0, 16'h1234);
      add(0, 4'd0, 16'h0000, 1, 4'b0000, 64'h0, 1, 4'b0000, 64'h0,                   3'd2, 1, 4'd3, 2'd2, 16'hBEEF);
      add(0, 4'd0, 16'h0000, 1, 4'b0000, 64'h0, 1, 4'b0000, 64'h0,                   3'd2, 0, 4'd0, 2'd0, 16'h0);
      // Consumer stalls: one result held, all four cores occupied, three of them DONE.
      add(1, 4'd6, 16'h0A06, 0, 4'b0000, 64'h0, 1, 4'b0000, 64'h0,                   3'd2, 0, 4'd0, 2'd0, 16'h0);
      add(1, 4'd7, 16'h0A07, 0, 4'b0010, 64'h0000_0000_0200_0000, 1, 4'b0001, 64'h0000_0000_0000_0A06, 3'd3, 0, 4'd0, 2'd0, 16'h0);
      add(0, 4'd0, 16'h0000, 0, 4'b0000, 64'h0, 0, 4'b0100, 64'h0000_0A07_0000_0000, 3'd4, 0, 4'd0, 2'd0, 16'h0);
      add(1, 4'd8, 16'h0A08, 0, 4'b0000, 64'h0, 1, 4'b0000, 64'h0,                   3'd3, 1, 4'd2, 2'd1, 16'h0200);
      add(0, 4'd0, 16'h0000, 0, 4'b1101, 64'h0400_0700_0000_0600, 0, 4'b0010, 64'h0000_0000_0A08_0000, 3'd4, 1, 4'd2, 2'd1, 16'h0200);
      for (int k = 0; k < 9; k++)
         add(0, 4'd0, 16'h0000, 0, 4'b0000, 64'h0, 0, 4'b0000, 64'h0,                3'd4, 1, 4'd2, 2'd1, 16'h0200);
      // Release: three results in three cycles, then cores are reused.
      add(0, 4'd0, 16'h0000, 1, 4'b0000, 64'h0, 0, 4'b0000, 64'h0,                   3'd4, 1, 4'd2, 2'd1, 16'h0200);
      add(0, 4'd0, 16'h0000, 1, 4'b0000, 64'h0, 1, 4'b0000, 64'h0,                   3'd3, 1, 4'd7, 2'd2, 16'h0700);
      add(0, 4'd0, 16'h0000, 1, 4'b0000, 64'h0, 1, 4'b0000, 64'h0,                   3'd2, 1, 4'd4, 2'd3, 16'h0400);
      add(0, 4'd0, 16'h0000, 1, 4'b0000, 64'h0, 1, 4'b0000, 64'h0,                   3'd1, 1, 4'd6, 2'd0, 16'h0600);
      add(1, 4'd9, 16'h0A09, 1, 4'b0000, 64'h0, 1, 4'b0000, 64'h0,                   3'd1, 0, 4'd0, 2'd0, 16'h0);
      add(1, 4'd10, 16'h0A0A, 1, 4'b0000, 64'h0, 1, 4'b0100, 64'h0000_0A09_0000_0000, 3'd2, 0, 4'd0, 2'd0, 16'h0);
      add(0, 4'd0, 16'h0000, 1, 4'b0000, 64'h0, 1, 4'b1000, 64'h0A0A_0000_0000_0000, 3'd3, 0, 4'd0, 2'd0, 16'h0);

      rst_n       = 1'b0;
      job_valid   = 1'b0;
      job_tag     = '0;
      job_data    = '0;
      res_ready   = 1'b0;
      core_done   = '0;
      core_result = '0;

      // Reset state.
      repeat (2) @(negedge clk);
      #1;
      check("rst job_ready",    64'(job_ready),    64'h0);
      check("rst res_valid",    64'(res_valid),    64'h0);
      check("rst res_tag",      64'(res_tag),      64'h0);
      check("rst res_core",     64'(res_core),     64'h0);
      check("rst res_data",     64'(res_data),     64'h0);
      check("rst core_start",   64'(core_start),   64'h0);
      check("rst core_data",    core_data,         64'h0);
      check("rst busy_cnt",     64'(busy_cnt),     64'h0);
      check("rst err_spurious", 64'(err_spurious), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst release job_ready", 64'(job_ready), 64'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         job_valid   = vecs[i].jv;
         job_tag     = vecs[i].tag;
         job_data    = vecs[i].jdata;
         res_ready   = vecs[i].rr;
         core_done   = vecs[i].cdone;
         core_result = vecs[i].cres;
         #1;
         check($sformatf("v%0d job_ready", i),    64'(job_ready),    64'(vecs[i].e_ready));
         check($sformatf("v%0d core_start", i),   64'(core_start),   64'(vecs[i].e_start));
         check($sformatf("v%0d core_data", i),    core_data,         vecs[i].e_cdata);
         check($sformatf("v%0d busy_cnt", i),     64'(busy_cnt),     64'(vecs[i].e_busy));
         check($sformatf("v%0d res_valid", i),    64'(res_valid),    64'(vecs[i].e_rv));
         check($sformatf("v%0d err_spurious", i), 64'(err_spurious), 64'h0);
         if (vecs[i].e_rv) begin
            check($sformatf("v%0d res_tag", i),  64'(res_tag),  64'(vecs[i].e_tag));
            check($sformatf("v%0d res_core", i), 64'(res_core), 64'(vecs[i].e_core));
            check($sformatf("v%0d res_data", i), 64'(res_data), 64'(vecs[i].e_data));
         end
      end

      // Reset pulse with three cores busy: everything cleared, next job lands on core 0.
      @(negedge clk);
      job_valid   = 1'b0;
      core_done   = '0;
      core_result = '0;
      rst_n       = 1'b0;
      #1;
      check("midrst busy_cnt",   64'(busy_cnt),   64'h0);
      check("midrst res_valid",  64'(res_valid),  64'h0);
      check("midrst job_ready",  64'(job_ready),  64'h0);
      check("midrst core_start", 64'(core_start), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("midrst release job_ready", 64'(job_ready), 64'h0);
      @(negedge clk);
      #1;
      check("midrst job_ready", 64'(job_ready), 64'h1);
      job_valid = 1'b1;
      job_tag   = 4'hB;
      job_data  = 16'h0B0B;
      @(negedge clk);
      job_valid = 1'b0;
      #1;
      check("midrst core_start", 64'(core_start), 64'h1);
      check("midrst core_data",  core_data,       64'h0000_0000_0000_0B0B);
      check("midrst busy_cnt",   64'(busy_cnt),   64'h1);

      // Spurious done on idle core 1: sticky error, nothing collected.
      res_ready = 1'b1;
      @(negedge clk);
      core_done   = 4'b0010;
      core_result = 64'h0000_0000_DEAD_0000;
      #1;
      check("spur err before", 64'(err_spurious), 64'h0);
      @(negedge clk);
      core_done   = '0;
      core_result = '0;
      #1;
      check("spur err set", 64'(err_spurious), 64'h1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("spur err sticky %0d", k), 64'(err_spurious), 64'h1);
         check($sformatf("spur res_valid %0d", k),  64'(res_valid),    64'h0);
         check($sformatf("spur busy_cnt %0d", k),   64'(busy_cnt),     64'h1);
      end
      // Genuine completion on core 0 still returns normally.
      @(negedge clk);
      core_done   = 4'b0001;
      core_result = 64'h0000_0000_0000_5555;
      @(negedge clk);
      core_done   = '0;
      core_result = '0;
      #1;
      check("post res_valid early", 64'(res_valid), 64'h0);
      @(negedge clk);
      #1;
      check("post res_valid", 64'(res_valid),    64'h1);
      check("post res_tag",   64'(res_tag),      64'hB);
      check("post res_core",  64'(res_core),     64'h0);
      check("post res_data",  64'(res_data),     64'h5555);
      check("post err",       64'(err_spurious), 64'h1);
      check("post busy_cnt",  64'(busy_cnt),     64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
